// File: rtl/count_distance_timer.sv
// Elapsed-tick counter with a registered |count - target| distance and early/late flags.
// A start captures the target; counting ends on stop_i or on an optional overrun timeout.
module count_distance_timer #(
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             tick_i,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic [WIDTH-1:0] target_i,
  output logic [WIDTH-1:0] count_o,
  output logic [WIDTH-1:0] distance_o,
  output logic             late_o,
  output logic             on_target_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             timeout_o,
  output logic             sat_o
);

  localparam logic [1:0]       S_IDLE  = 2'd0;
  localparam logic [1:0]       S_RUN   = 2'd1;
  localparam logic [1:0]       S_HOLD  = 2'd2;
  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [WIDTH:0]   TO_LIM  = (WIDTH+1)'(TIMEOUT);
  localparam bit               TO_EN   = (TIMEOUT != 0);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] tgt_q, tgt_d;
  logic [WIDTH-1:0] dist_q, dist_d;
  logic             late_q, late_d;
  logic             ont_q, ont_d;
  logic             done_q, done_d;
  logic             to_q, to_d;
  logic             sat_q, sat_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tgt_d   = tgt_q;
    to_d    = to_q;
    sat_d   = sat_q;
    done_d  = 1'b0;
    case (state_q)
      S_RUN: begin
        // stop beats a simultaneous tick, so the tick is dropped
        if (stop_i) begin
          state_d = S_HOLD;
          done_d  = 1'b1;
        end else if (tick_i) begin
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
          if (cnt_d == CNT_MAX) sat_d = 1'b1;
          if (TO_EN && (cnt_d > tgt_q) && ({1'b0, cnt_d - tgt_q} >= TO_LIM)) begin
            state_d = S_HOLD;
            done_d  = 1'b1;
            to_d    = 1'b1;
          end
        end
      end
      default: begin
        if (start_i) begin
          state_d = S_RUN;
          cnt_d   = '0;
          tgt_d   = target_i;
          to_d    = 1'b0;
          sat_d   = 1'b0;
        end
      end
    endcase
    // flags come from the next count so they line up with count_o
    late_d = (cnt_d > tgt_d);
    ont_d  = (cnt_d == tgt_d);
    dist_d = late_d ? (cnt_d - tgt_d) : (tgt_d - cnt_d);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      tgt_q   <= '0;
      dist_q  <= '0;
      late_q  <= 1'b0;
      ont_q   <= 1'b1;
      done_q  <= 1'b0;
      to_q    <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tgt_q   <= tgt_d;
      dist_q  <= dist_d;
      late_q  <= late_d;
      ont_q   <= ont_d;
      done_q  <= done_d;
      to_q    <= to_d;
      sat_q   <= sat_d;
    end
  end

  assign count_o     = cnt_q;
  assign distance_o  = dist_q;
  assign late_o      = late_q;
  assign on_target_o = ont_q;
  assign busy_o      = (state_q == S_RUN);
  assign done_o      = done_q;
  assign timeout_o   = to_q;
  assign sat_o       = sat_q;

endmodule

// File: tb/tb_count_distance_timer.sv
// Scoreboard bench: two instances (4-bit no timeout, 8-bit TIMEOUT=4) share stimulus
// and are compared every cycle against a per-cycle behavioural model.
module tb_count_distance_timer;

  typedef struct {
    int st;   // 0 idle, 1 run, 2 hold
    int cnt;
    int tgt;
    int done;
    int to;
    int sat;
  } mst_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick = 1'b0, start = 1'b0, stop = 1'b0;
  logic [7:0] target = '0;

  logic [3:0] cnt_a, dist_a;
  logic       late_a, ont_a, busy_a, done_a, to_a, sat_a;
  logic [7:0] cnt_b, dist_b;
  logic       late_b, ont_b, busy_b, done_b, to_b, sat_b;

  int total = 0;
  int bad   = 0;

  mst_t ma, mb;
  mst_t qa[$];
  mst_t qb[$];

  count_distance_timer #(.WIDTH(4), .TIMEOUT(0)) dut_a (
    .clk_i(clk), .rst_i(rst), .tick_i(tick), .start_i(start), .stop_i(stop),
    .target_i(target[3:0]), .count_o(cnt_a), .distance_o(dist_a), .late_o(late_a),
    .on_target_o(ont_a), .busy_o(busy_a), .done_o(done_a), .timeout_o(to_a), .sat_o(sat_a));

  count_distance_timer #(.WIDTH(8), .TIMEOUT(4)) dut_b (
    .clk_i(clk), .rst_i(rst), .tick_i(tick), .start_i(start), .stop_i(stop),
    .target_i(target), .count_o(cnt_b), .distance_o(dist_b), .late_o(late_b),
    .on_target_o(ont_b), .busy_o(busy_b), .done_o(done_b), .timeout_o(to_b), .sat_o(sat_b));

  always #5 clk = ~clk;

  function automatic mst_t m_reset();
    mst_t s;
    s.st = 0; s.cnt = 0; s.tgt = 0; s.done = 0; s.to = 0; s.sat = 0;
    return s;
  endfunction

  function automatic mst_t m_step(mst_t s, bit st_i, bit sp_i, bit tk_i, int tg, int w, int tmo);
    int mx;
    mx = (1 << w) - 1;
    s.done = 0;
    if (s.st != 1) begin
      if (st_i) begin
        s.st = 1; s.cnt = 0; s.tgt = tg & mx; s.to = 0; s.sat = 0;
      end
    end else if (sp_i) begin
      s.st = 2; s.done = 1;
    end else if (tk_i) begin
      if (s.cnt < mx) s.cnt++;
      if (s.cnt == mx) s.sat = 1;
      if (tmo != 0 && s.cnt > s.tgt && s.cnt - s.tgt >= tmo) begin
        s.st = 2; s.done = 1; s.to = 1;
      end
    end
    return s;
  endfunction

  task automatic chk(string nm, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp(string p, mst_t e, int c, int d, bit lt, bit on, bit bz, bit dn, bit tm, bit sa);
    chk({p, "_count"}, c, e.cnt);
    chk({p, "_distance"}, d, (e.cnt > e.tgt) ? e.cnt - e.tgt : e.tgt - e.cnt);
    chk({p, "_late"}, int'(lt), int'(e.cnt > e.tgt));
    chk({p, "_on_target"}, int'(on), int'(e.cnt == e.tgt));
    chk({p, "_busy"}, int'(bz), int'(e.st == 1));
    chk({p, "_done"}, int'(dn), e.done);
    chk({p, "_timeout"}, int'(tm), e.to);
    chk({p, "_sat"}, int'(sa), e.sat);
  endtask

  // monitor: outputs are valid every cycle, so each negedge retires one expectation
  always @(negedge clk) begin
    if (qa.size() > 0) begin
      mst_t e;
      e = qa.pop_front();
      cmp("a", e, cnt_a, dist_a, late_a, ont_a, busy_a, done_a, to_a, sat_a);
    end
    if (qb.size() > 0) begin
      mst_t e;
      e = qb.pop_front();
      cmp("b", e, cnt_b, dist_b, late_b, ont_b, busy_b, done_b, to_b, sat_b);
    end
  end

  task automatic cyc(bit st_i, bit sp_i, bit tk_i, int tg);
    start = st_i; stop = sp_i; tick = tk_i; target = 8'(tg);
    @(posedge clk);
    ma = m_step(ma, st_i, sp_i, tk_i, tg, 4, 0);
    mb = m_step(mb, st_i, sp_i, tk_i, tg, 8, 4);
    qa.push_back(ma);
    qb.push_back(mb);
    @(negedge clk);
    #1;
  endtask

  // asserts reset between edges and checks the outputs clear before any clock edge
  task automatic do_reset();
    rst = 1'b1;
    #1;
    ma = m_reset();
    mb = m_reset();
    cmp("a_async_rst", ma, cnt_a, dist_a, late_a, ont_a, busy_a, done_a, to_a, sat_a);
    cmp("b_async_rst", mb, cnt_b, dist_b, late_b, ont_b, busy_b, done_b, to_b, sat_b);
    @(posedge clk);
    qa.push_back(ma);
    qb.push_back(mb);
    @(negedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    ma = m_reset();
    mb = m_reset();
    #3;
    do_reset();

    // target 5, three ticks, stop
    cyc(1, 0, 0, 5);
    repeat (3) cyc(0, 0, 1, 0);
    cyc(0, 1, 0, 0);
    chk("tp1_count", cnt_a, 3);
    chk("tp1_distance", dist_a, 2);
    chk("tp1_busy", busy_a, 0);
    cyc(0, 0, 0, 0);

    // restart from HOLD, 8 ticks, stop with a 9th tick
    cyc(1, 0, 0, 5);
    chk("tp2_restart_dist", dist_a, 5);
    repeat (5) cyc(0, 0, 1, 0);
    chk("tp2_on_target", ont_a, 1);
    repeat (3) cyc(0, 0, 1, 0);
    cyc(0, 1, 1, 0);
    chk("tp2_count", cnt_a, 8);
    chk("tp2_late", late_a, 1);

    // auto-stop on the 8-bit instance, then stimulus in HOLD must not move it
    cyc(1, 0, 0, 2);
    repeat (10) cyc(0, 0, 1, 0);
    chk("tp3_count_b", cnt_b, 6);
    chk("tp3_timeout_b", to_b, 1);
    cyc(0, 1, 1, 0);

    // saturation on the 4-bit instance; a start while running is ignored
    cyc(1, 0, 0, 0);
    repeat (20) cyc(0, 0, 1, 0);
    chk("tp4_count_a", cnt_a, 15);
    chk("tp4_sat_a", sat_a, 1);
    cyc(1, 0, 1, 9);
    cyc(0, 1, 0, 0);

    // reset in the middle of a run
    cyc(1, 0, 0, 7);
    repeat (3) cyc(0, 0, 1, 0);
    do_reset();

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
      end else begin
        cyc($urandom_range(0, 19) == 0, $urandom_range(0, 24) == 0,
            $urandom_range(0, 2) != 0, int'($urandom_range(0, 20)));
      end
    end

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("queue_drained", qa.size() + qb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
